// File: rtl/seg_display_scheduler.sv
// Round-robin time-sharing of one 8-bit seven-segment display between N_REQ producers.
// Each grant shows a latched pattern for DWELL_CYCLES, then one blank GAP cycle.
module seg_display_scheduler #(
    parameter int          N_REQ        = 4,
    parameter int          DWELL_CYCLES = 1000,
    parameter logic [7:0]  BLANK        = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   seg_in,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           seg_out,
    output logic                 busy
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int PTR_W = $clog2(N_REQ);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [PTR_W:0]   N_WIDE   = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;

    logic [7:0]         slots [N_REQ];
    logic [2*N_REQ-1:0] req_rot;
    logic [PTR_W:0]     pick_sum;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign slots[g] = seg_in[8*g +: 8];
    end

    // Rotate so bit 0 is the pointer's requester; the lowest set bit is the winner's offset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        req_rot    = {req, req} >> ptr;
        pick_valid = 1'b0;
        pick_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_valid && req_rot[i]) begin
                pick_valid = 1'b1;
                pick_sum   = {1'b0, ptr} + (PTR_W+1)'(i);
            end
        end
        if (pick_sum >= N_WIDE) begin
            pick_sum = pick_sum - N_WIDE;
        end
        pick = pick_sum[PTR_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            owner   <= '0;
            grant   <= '0;
            ack     <= '0;
            seg_out <= BLANK;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state   <= ST_SHOW;
                        owner   <= pick;
                        grant   <= ONE_HOT0 << pick;
                        seg_out <= slots[pick];
                        cnt     <= '0;
                        ptr     <= (pick == PTR_LAST) ? '0 : pick + 1'b1;
                    end
                end
                ST_SHOW: begin
                    // A withdrawn request aborts without ack, even on the final dwell cycle.
                    if (!req[owner]) begin
                        state   <= ST_GAP;
                        grant   <= '0;
                        seg_out <= BLANK;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_GAP;
                        grant   <= '0;
                        ack     <= ONE_HOT0 << owner;
                        seg_out <= BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                    ack   <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    grant   <= '0;
                    ack     <= '0;
                    seg_out <= BLANK;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with N_REQ=4, DWELL_CYCLES=4.
module tb_seg_display_scheduler;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b1;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] seg_in = '0;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic [7:0]   seg_out;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    seg_display_scheduler #(
        .N_REQ(N),
        .DWELL_CYCLES(D),
        .BLANK(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .req(req),
        .seg_in(seg_in),
        .grant(grant),
        .ack(ack),
        .seg_out(seg_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_ack"}, 32'(ack), 32'h0);
        check({tag, "_seg"}, 32'(seg_out), 32'h00);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        #1 rst = 1'b0;
    endtask

    logic [N-1:0] rr_exp [5];
    logic [7:0]   rr_seg [5];
    int n_g;
    int n_a;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_seg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        tick();
        pulse_reset("rst0");

        // Single request from slot 2.
        seg_in = 32'h00E7_0000;
        req    = 4'b0100;
        for (int c = 0; c < D; c++) begin
            tick();
            check($sformatf("single_grant_c%0d", c), 32'(grant), 32'h4);
            check($sformatf("single_seg_c%0d", c), 32'(seg_out), 32'hE7);
        end
        tick();
        check("single_gap_ack", 32'(ack), 32'h4);
        check("single_gap_grant", 32'(grant), 32'h0);
        check("single_gap_seg", 32'(seg_out), 32'h00);
        check("single_gap_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        check("single_idle_ack", 32'(ack), 32'h0);
        check("single_idle_busy", 32'(busy), 32'h0);

        // Pointer is back at 0 after reset, so requester 0 wins first.
        pulse_reset("rst1");
        seg_in = 32'h4433_2211;
        req    = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < D; c++) begin
                tick();
                check($sformatf("rr%0d_grant_c%0d", k, c), 32'(grant), 32'(rr_exp[k]));
                if (c == 0) check($sformatf("rr%0d_seg", k), 32'(seg_out), 32'(rr_seg[k]));
            end
            tick();
            check($sformatf("rr%0d_gap_ack", k), 32'(ack), 32'(rr_exp[k]));
            check($sformatf("rr%0d_gap_grant", k), 32'(grant), 32'h0);
            tick();
            check($sformatf("rr%0d_idle_ack", k), 32'(ack), 32'h0);
            check($sformatf("rr%0d_idle_busy", k), 32'(busy), 32'h0);
        end
        req = 4'b0000;
        tick();
        check("rr_end_idle", 32'(busy), 32'h0);

        // Abort: requester 1 withdraws in its 2nd SHOW cycle; requester 3 is next.
        pulse_reset("rst2");
        req = 4'b1010;
        tick();
        check("abort_grant_c0", 32'(grant), 32'h2);
        tick();
        check("abort_grant_c1", 32'(grant), 32'h2);
        req = 4'b1000;
        tick();
        check("abort_gap_grant", 32'(grant), 32'h0);
        check("abort_gap_ack", 32'(ack), 32'h0);
        check("abort_gap_seg", 32'(seg_out), 32'h00);
        check("abort_gap_busy", 32'(busy), 32'h1);
        tick();
        check("abort_idle_busy", 32'(busy), 32'h0);
        tick();
        check("abort_next_grant", 32'(grant), 32'h8);
        check("abort_next_seg", 32'(seg_out), 32'h44);

        // Freeze for 3 cycles in requester 3's dwell: 7 grant cycles, one ack.
        n_g = 1;
        n_a = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) ena = 1'b0;
            if (i == 4) ena = 1'b1;
            tick();
            if (grant == 4'b1000) n_g++;
            if (ack == 4'b1000) begin
                n_a++;
                req = 4'b0000;
            end
        end
        check("freeze_grant_cycles", 32'(n_g), 32'd7);
        check("freeze_ack_count", 32'(n_a), 32'd1);

        // Latched pattern ignores seg_in changes; async reset drops the dwell.
        seg_in = 32'h4433_223C;
        req    = 4'b0001;
        tick();
        check("stab_grant", 32'(grant), 32'h1);
        check("stab_seg0", 32'(seg_out), 32'h3C);
        seg_in = 32'h4433_22FF;
        tick();
        check("stab_seg1", 32'(seg_out), 32'h3C);
        tick();
        check("stab_seg2", 32'(seg_out), 32'h3C);
        pulse_reset("rst3");
        tick();
        check("post_rst_grant", 32'(grant), 32'h1);
        check("post_rst_seg", 32'(seg_out), 32'hFF);
        n_a = 0;
        for (int i = 0; i < D - 1; i++) begin
            tick();
            if (ack != 4'b0000) n_a++;
        end
        check("post_rst_early_ack", 32'(n_a), 32'd0);
        tick();
        check("post_rst_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        check("final_idle_busy", 32'(busy), 32'h0);
        check("final_idle_seg", 32'(seg_out), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Time-shares the single 8-bit seven-segment output (`uo_out`) between up to N_REQ producers, such as the sequence-detector status, the BCD digit decoder and the segment test-pattern walker. Each producer raises a request with its pattern. The block grants the display round-robin, holds each pattern for a fixed dwell time, acknowledges completion, and blanks the display for one cycle between owners. It sits between the producers and the top-level `uo_out` assignment.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `DWELL_CYCLES`, default 1000: cycles a granted pattern is shown (>= 1).
- `BLANK`, default 8'h00: pattern driven when no owner is on the display.

- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ena`  in  1  enable; when low, all state and outputs are frozen.
- `req`  in  N_REQ  per-requester request, level, held until ack or withdrawn.
- `seg_in`  in  8*N_REQ  patterns; slot i is `seg_in[8*i+7:8*i]`.
- `grant`  out  N_REQ  one-hot owner of the display; all zero when none.
- `ack`  out  N_REQ  one-hot, one-cycle pulse: the owner completed its full dwell.
- `seg_out`  out  8  registered display pattern.
- `busy`  out  1  high while in SHOW or GAP.

## Operation
- Reset values: state=IDLE, `grant`=0, `ack`=0, `seg_out`=BLANK, `busy`=0, dwell counter=0, round-robin pointer=0 (requester 0 highest priority).
- States: IDLE, SHOW, GAP. All transitions require `ena`=1.
- IDLE, with `req`!=0:
  - Pick the first set bit at or after the pointer, wrapping modulo N_REQ; call it w.
  - Go to SHOW with `grant`=onehot(w), `seg_out`=seg_in slot w, counter=0, pointer=w+1 (wraps).
- IDLE, with `req`=0: stay in IDLE; outputs hold their reset/idle values.
- SHOW, counter < DWELL_CYCLES-1 and `req[w]`=1: increment the counter. `seg_out` holds the value latched at grant; changes on `seg_in` are ignored.
- SHOW, counter == DWELL_CYCLES-1 and `req[w]`=1: go to GAP with `ack`=onehot(w), `grant`=0, `seg_out`=BLANK.
- SHOW, `req[w]`=0 (abort): go to GAP on the next edge with `ack`=0, `grant`=0, `seg_out`=BLANK.
  - Abort takes priority over completion when both occur on the same cycle.
- GAP: lasts one cycle, then IDLE; `ack` returns to 0.
  - A requester still holding `req` in GAP is treated as a fresh request.
  - It receives its next grant only after every other pending requester has been served.
- Requests from non-owners during SHOW or GAP are remembered only as levels; there is no queueing.
- Counter width is clog2(DWELL_CYCLES) bits and never exceeds DWELL_CYCLES-1.

## Timing
- Request seen in IDLE at edge k: `grant` and `seg_out` are valid after edge k.
- SHOW lasts exactly DWELL_CYCLES enabled cycles with `grant` high.
- GAP follows for 1 cycle (`ack` high on completion), then IDLE for 1 cycle.
- Minimum slot period is DWELL_CYCLES+2 enabled cycles; with continuous requests this is also the grant spacing.
- `ena`=0 stretches the current state by exactly the number of disabled cycles, and `ack` stays high if it was high.
- `rst` asserted at any time clears everything immediately, without waiting for a clock edge; an in-progress dwell is lost and produces no `ack`.
  - The first edge after `rst` deasserts is an IDLE arbitration.

## Test plan
- Reset check: pulse `rst` mid-cycle -> `grant`=0, `ack`=0, `seg_out`=8'h00 and `busy`=0 asynchronously; pointer=0, verified by the next test's arbitration order.
- Single request (DWELL=4, N=4): `req`=4'b0100, slot 2=8'hE7 -> `grant`=0100 and `seg_out`=E7 for 4 cycles, then `ack`=0100 with `seg_out`=00 for 1 cycle, then IDLE.
- Round robin: `req`=4'b1111 held forever -> grants 0001, 0010, 0100, 1000, 0001, each 4 cycles long, rising 6 cycles apart.
- Abort: `req[1]` drops in the 2nd SHOW cycle -> next edge enters GAP with `ack`=0000 and `seg_out`=00; next grant goes to the next pending requester after 1.
- Freeze: `ena`=0 for 3 cycles mid-SHOW -> `grant` is high for 7 cycles total and `ack` appears once.
- Pattern stability: change slot w of `seg_in` during SHOW -> `seg_out` unchanged; async `rst` mid-SHOW -> immediate BLANK and no `ack`.
